// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg -- shared definitions for the mem_backing_store slice.
//
// Contents:
//   state_e       : 2-bit FSM state encoding (IDLE / WAIT / RESP)
//   INIT_PATTERN  : power-up fill pattern; word[a] = INIT_PATTERN | a
//   CNT_WIDTH     : width of the latency down-counter (LATENCY <= 15)
//   init_word()   : helper that builds the power-up value of one word
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] INIT_PATTERN = 32'hCAFE0000;

  localparam int CNT_WIDTH = 4;

  // Power-up contents of word 'addr': the pattern with the zero-extended
  // word address OR-ed into the low bits.
  function automatic logic [31:0] init_word(input int unsigned addr);
    return INIT_PATTERN | addr;
  endfunction

endpackage

// File: rtl/mem_backing_store_if.sv
// ---------------------------------------------------------------------------
// mem_backing_store_if -- request/response bus between a cache controller
// (master) and the backing store (slave).
//
// Signals:
//   req_valid  m->s  request present
//   req_ready  s->m  store can accept a request
//   req_write  m->s  1 = write, 0 = read
//   req_addr   m->s  word address (ADDR_WIDTH)
//   req_wdata  m->s  write data (DATA_WIDTH)
//   resp_valid s->m  response present
//   resp_ready m->s  controller accepts the response
//   resp_rdata s->m  read data, or the written data for a write
// ---------------------------------------------------------------------------
interface mem_backing_store_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/mem_latency_counter.sv
// ---------------------------------------------------------------------------
// mem_latency_counter -- loadable down-counter that times the WAIT state.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, clears the count
//   load      in   load load_val (has priority over dec)
//   load_val  in   value loaded on 'load'
//   dec       in   decrement by one; holds at zero
//   zero      out  count is zero
// ---------------------------------------------------------------------------
module mem_latency_counter
  import mem_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_backing_store.sv
// ---------------------------------------------------------------------------
// mem_backing_store -- fixed-latency word memory behind a cache.
//
// One request at a time: a request is accepted in IDLE, the FSM waits
// LATENCY cycles in WAIT and then presents the response in RESP until the
// consumer takes it. Writes commit to the array on the acceptance edge; the
// response echoes the written data.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (array contents survive it)
//   bus       if   mem_backing_store_if.slave request/response bus
//   busy      out  FSM is not in IDLE
//   rd_count  out  accepted reads, saturating  (MEM_BACKING_STORE_STATS_EN)
//   wr_count  out  accepted writes, saturating (MEM_BACKING_STORE_STATS_EN)
//
// Optional feature: define MEM_BACKING_STORE_STATS_EN to add the read/write
// statistics counters and their ports.
//
// Parameters: ADDR_WIDTH (word address), DATA_WIDTH, LATENCY (1..15).
// ---------------------------------------------------------------------------
module mem_backing_store
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_backing_store_if.slave    bus,
  output logic                  busy
`ifdef MEM_BACKING_STORE_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(LATENCY - 1);

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  accept;
  logic                  mem_we;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept = bus.req_valid && (state_q == ST_IDLE);
  assign mem_we = accept && bus.req_write;

  // -------------------------------------------------------------------------
  // Storage: one register per word so that each word can carry its own
  // power-up value. Reset never touches these registers, so a committed
  // write survives a reset that aborts its response.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] words [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    localparam logic [31:0] INIT_WORD = init_word(gi);

    logic [DATA_WIDTH-1:0] word_q = DATA_WIDTH'(INIT_WORD);
    logic [DATA_WIDTH-1:0] word_d;

    always_comb begin
      word_d = word_q;
      if (mem_we && (bus.req_addr == ADDR_WIDTH'(gi))) begin
        word_d = bus.req_wdata;
      end
    end

    always_ff @(posedge clk) begin
      word_q <= word_d;
    end

    assign words[gi] = word_q;
  end

  assign rd_word = words[addr_q];

  // -------------------------------------------------------------------------
  // WAIT countdown: loaded with LATENCY-1 on acceptance, so RESP is entered
  // exactly LATENCY edges after the acceptance edge.
  // -------------------------------------------------------------------------
  mem_latency_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_latency_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // -------------------------------------------------------------------------
  // FSM next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_WAIT;
          addr_d   = bus.req_addr;
          write_d  = bus.req_write;
          wdata_d  = bus.req_wdata;
          cnt_load = 1'b1;
        end
      end

      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_RESP;
          // A write's array word already equals wdata_q; taking it from the
          // latch keeps the echo independent of the array read path.
          rdata_d = write_q ? wdata_q : rd_word;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign busy           = (state_q != ST_IDLE);

`ifdef MEM_BACKING_STORE_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating statistics on accepted requests
  // -------------------------------------------------------------------------
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (accept && !bus.req_write && (rd_count_q != 16'hFFFF)) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (accept && bus.req_write && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_backing_store.sv
// ---------------------------------------------------------------------------
// tb_mem_backing_store -- directed self-checking bench.
// dut_a runs with LATENCY=4, dut_b with LATENCY=1. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_backing_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid    [2];
  logic        req_write    [2];
  logic [10:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        resp_ready   [2];
  logic        req_ready_o  [2];
  logic        resp_valid_o [2];
  logic        busy_o       [2];
  logic [31:0] resp_rdata_o [2];

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic seen;

`ifdef MEM_BACKING_STORE_STATS_EN
  logic [15:0] rd_a, wr_a, rd_b, wr_b;
`endif

  mem_backing_store_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) if_a ();
  mem_backing_store_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) if_b ();

  assign if_a.req_valid  = req_valid[0];
  assign if_a.req_write  = req_write[0];
  assign if_a.req_addr   = req_addr[0];
  assign if_a.req_wdata  = req_wdata[0];
  assign if_a.resp_ready = resp_ready[0];
  assign req_ready_o[0]  = if_a.req_ready;
  assign resp_valid_o[0] = if_a.resp_valid;
  assign resp_rdata_o[0] = if_a.resp_rdata;

  assign if_b.req_valid  = req_valid[1];
  assign if_b.req_write  = req_write[1];
  assign if_b.req_addr   = req_addr[1];
  assign if_b.req_wdata  = req_wdata[1];
  assign if_b.resp_ready = resp_ready[1];
  assign req_ready_o[1]  = if_b.req_ready;
  assign resp_valid_o[1] = if_b.resp_valid;
  assign resp_rdata_o[1] = if_b.resp_rdata;

  mem_backing_store #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .LATENCY(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a),
    .busy  (busy_o[0])
`ifdef MEM_BACKING_STORE_STATS_EN
    ,
    .rd_count (rd_a),
    .wr_count (wr_a)
`endif
  );

  mem_backing_store #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .LATENCY(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b),
    .busy  (busy_o[1])
`ifdef MEM_BACKING_STORE_STATS_EN
    ,
    .rd_count (rd_b),
    .wr_count (wr_b)
`endif
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issue one request from a falling edge with the DUT idle; returns at the
  // falling edge where resp_valid is first seen, with the number of rising
  // edges since acceptance (or the bound, if it never came).
  task automatic do_req(input int s, input logic w, input logic [10:0] a,
                        input logic [31:0] d, output int n);
    req_valid[s] = 1'b1;
    req_write[s] = w;
    req_addr[s]  = a;
    req_wdata[s] = d;
    @(negedge clk);
    req_valid[s] = 1'b0;
    n = 0;
    while (!resp_valid_o[s] && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    $display("req dut%0d %s addr=%h lat=%0d rdata=%h", s, w ? "WR" : "RD", a, n, resp_rdata_o[s]);
  endtask

  // Accept the pending response and check the store is idle afterwards.
  task automatic take(input int s);
    resp_ready[s] = 1'b1;
    @(negedge clk);
    chk1("resp_dropped", resp_valid_o[s], 1'b0);
    chk1("ready_again", req_ready_o[s], 1'b1);
    resp_ready[s] = (s == 1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_write[s] = 1'b0;
      req_addr[s]  = '0;
      req_wdata[s] = '0;
    end
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk1("rst_req_ready", req_ready_o[s], 1'b1);
      chk1("rst_resp_valid", resp_valid_o[s], 1'b0);
      chk1("rst_busy", busy_o[s], 1'b0);
      chk32("rst_rdata", resp_rdata_o[s], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // LATENCY=4 read of an untouched word
    do_req(0, 1'b0, 11'h005, 32'h0, lat);
    chk32("rd005_lat", 32'(lat), 32'd4);
    chk32("rd005_data", resp_rdata_o[0], 32'hCAFE0005);
    chk1("rd005_busy", busy_o[0], 1'b1);

    // Back-pressure: response held, writes to 0AA presented and ignored
    for (int i = 0; i < 3; i++) begin
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 11'h0AA;
      req_wdata[0] = 32'h0BADF00D;
      @(negedge clk);
      chk1("stall_valid", resp_valid_o[0], 1'b1);
      chk32("stall_data", resp_rdata_o[0], 32'hCAFE0005);
      chk1("stall_req_ready", req_ready_o[0], 1'b0);
    end
    req_valid[0] = 1'b0;
    req_write[0] = 1'b0;
    take(0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | resp_valid_o[0] | busy_o[0];
    end
    chk1("ignored_no_activity", seen, 1'b0);

    // Write then read back
    do_req(0, 1'b1, 11'h010, 32'hDEADBEEF, lat);
    chk32("wr010_lat", 32'(lat), 32'd4);
    chk32("wr010_echo", resp_rdata_o[0], 32'hDEADBEEF);
    take(0);
    do_req(0, 1'b0, 11'h010, 32'h0, lat);
    chk32("rd010_lat", 32'(lat), 32'd4);
    chk32("rd010_data", resp_rdata_o[0], 32'hDEADBEEF);
    take(0);
    do_req(0, 1'b0, 11'h0AA, 32'h0, lat);
    chk32("rd0AA_untouched", resp_rdata_o[0], 32'hCAFE00AA);
    take(0);

    // LATENCY=1 back-to-back reads on dut_b
    do_req(1, 1'b0, 11'h000, 32'h0, lat);
    chk32("l1_rd000_lat", 32'(lat), 32'd1);
    chk32("l1_rd000_data", resp_rdata_o[1], 32'hCAFE0000);
    take(1);
    do_req(1, 1'b0, 11'h7FF, 32'h0, lat);
    chk32("l1_rd7FF_lat", 32'(lat), 32'd1);
    chk32("l1_rd7FF_data", resp_rdata_o[1], 32'hCAFE07FF);
    take(1);

    // Reset during WAIT of a write
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 11'h020;
    req_wdata[0] = 32'h12345678;
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_write[0] = 1'b0;
    chk1("wr020_busy", busy_o[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("abort_resp_valid", resp_valid_o[0], 1'b0);
    chk1("abort_busy", busy_o[0], 1'b0);
    chk1("abort_req_ready", req_ready_o[0], 1'b1);
    chk32("abort_rdata", resp_rdata_o[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | resp_valid_o[0];
    end
    chk1("abort_no_resp", seen, 1'b0);
    $display("reset during WAIT of write 020 done");
`ifdef MEM_BACKING_STORE_STATS_EN
    chk32("stats_rd_after_rst", 32'(rd_a), 32'd0);
    chk32("stats_wr_after_rst", 32'(wr_a), 32'd0);
`endif

    do_req(0, 1'b0, 11'h020, 32'h0, lat);
    chk32("rd020_kept", resp_rdata_o[0], 32'h12345678);
    take(0);
    do_req(0, 1'b0, 11'h001, 32'h0, lat);
    chk32("rd001_data", resp_rdata_o[0], 32'hCAFE0001);
    take(0);
    do_req(0, 1'b0, 11'h7FF, 32'h0, lat);
    chk32("rd7FF_data", resp_rdata_o[0], 32'hCAFE07FF);
    take(0);
    do_req(0, 1'b1, 11'h003, 32'hAAAA5555, lat);
    chk32("wr003_echo", resp_rdata_o[0], 32'hAAAA5555);
    take(0);
    do_req(0, 1'b1, 11'h004, 32'h5555AAAA, lat);
    chk32("wr004_echo", resp_rdata_o[0], 32'h5555AAAA);
    take(0);

`ifdef MEM_BACKING_STORE_STATS_EN
    chk32("stats_rd", 32'(rd_a), 32'd3);
    chk32("stats_wr", 32'(wr_a), 32'd2);
    rst_n = 1'b0;
    #1;
    chk32("stats_rd_cleared", 32'(rd_a), 32'd0);
    chk32("stats_wr_cleared", 32'(wr_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
